mem_arbiter: RTL and testbench

Single-port memory arbiter for the pipelined MIPS core. It shares one unified instruction/data memory between the Fetch-stage instruction port and the Memory-stage data port. It sequences each access through a registered request/acknowledge handshake with variable memory latency, and returns per-port completion pulses. The pipeline uses the per-port stall outputs to freeze its stage registers until an access completes.

---
 rtl/mem_arb_pkg.sv | 20 ++
 rtl/arb_timer.sv | 36 +++
 rtl/mem_arbiter.sv | 137 +++++++++++++
 tb/tb_mem_arbiter.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and response encoding for the unified-memory arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2
    } arb_state_t;

    typedef enum logic {
        GNT_I = 1'b0,
        GNT_D = 1'b1
    } grant_t;

    // Completion code of a busy cycle: bit 0 = ready pulse, bit 1 = bus_err pulse.
    localparam logic [1:0] RSP_NONE = 2'b00;
    localparam logic [1:0] RSP_OK   = 2'b01;
    localparam logic [1:0] RSP_ERR  = 2'b11;

endpackage

// File: rtl/arb_timer.sv
// Access watchdog: loaded on grant, counts down while the access is outstanding,
// flags expire in the cycle the budget of TIMEOUT busy cycles is used up.
module arb_timer #(
    parameter int TIMEOUT = 64
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    input  logic clear,
    output logic expire
);

    localparam int CNT_W = $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] LOAD = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] count;
    logic             running;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count   <= '0;
            running <= 1'b0;
        end else if (start) begin
            count   <= LOAD;
            running <= 1'b1;
        end else if (clear) begin
            count   <= '0;
            running <= 1'b0;
        end else if (running && count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign expire = running && (count == '0);

endmodule

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter between the fetch and memory stages of the MIPS core,
// with registered memory handshake, starvation guard for fetch and access timeout.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int STREAK_MAX = 4,
    parameter int TIMEOUT    = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic [31:0] if_rdata,
    output logic        if_ready,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic [31:0] d_rdata,
    output logic        d_ready,
    output logic        stall_f,
    output logic        stall_m,
    output logic        m_req,
    output logic        m_we,
    output logic [31:0] m_addr,
    output logic [31:0] m_wdata,
    input  logic [31:0] m_rdata,
    input  logic        m_ack,
    output logic        bus_err,
    output logic        err_seen
);

    localparam int STREAK_W = $clog2(STREAK_MAX + 1);
    localparam logic [STREAK_W-1:0] STREAK_TOP = STREAK_W'(STREAK_MAX);

    arb_state_t          state;
    grant_t              gnt;
    logic [STREAK_W-1:0] streak;
    logic                ifElig;
    logic                dElig;
    logic                gntVld;
    logic                expire;
    logic                timerClear;
    logic [1:0]          rsp;

    function automatic logic [STREAK_W-1:0] streakNext(input logic [STREAK_W-1:0] cur,
                                                       input logic ifWaiting);
        if (!ifWaiting) return '0;
        return (cur == STREAK_TOP) ? cur : cur + 1'b1;
    endfunction

    // A port whose ready is high this cycle is dropping its request, so it must not be re-granted.
    always_comb begin
        ifElig = if_req & ~if_ready;
        dElig  = d_req & ~d_ready;
        gntVld = (state == IDLE) && (ifElig || dElig);
        gnt    = (dElig && (!ifElig || streak != STREAK_TOP)) ? GNT_D : GNT_I;
        rsp    = RSP_NONE;
        if (state != IDLE) begin
            if (m_ack) rsp = RSP_OK;
            else if (expire) rsp = RSP_ERR;
        end
        timerClear = (rsp != RSP_NONE);
    end

    arb_timer #(.TIMEOUT(TIMEOUT)) uTimer (
        .clk    (clk),
        .reset  (reset),
        .start  (gntVld),
        .clear  (timerClear),
        .expire (expire)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            streak   <= '0;
            m_req    <= 1'b0;
            m_we     <= 1'b0;
            m_addr   <= '0;
            m_wdata  <= '0;
            if_rdata <= '0;
            d_rdata  <= '0;
            if_ready <= 1'b0;
            d_ready  <= 1'b0;
            bus_err  <= 1'b0;
            err_seen <= 1'b0;
        end else begin
            if_ready <= 1'b0;
            d_ready  <= 1'b0;
            bus_err  <= 1'b0;
            case (state)
                IDLE: begin
                    if (gntVld) begin
                        m_req <= 1'b1;
                        if (gnt == GNT_D) begin
                            m_we    <= d_we;
                            m_addr  <= d_addr;
                            m_wdata <= d_wdata;
                            streak  <= streakNext(streak, if_req);
                            state   <= BUSY_D;
                        end else begin
                            m_we    <= 1'b0;
                            m_addr  <= if_addr;
                            m_wdata <= '0;
                            streak  <= '0;
                            state   <= BUSY_I;
                        end
                    end
                end
                BUSY_I, BUSY_D: begin
                    if (rsp != RSP_NONE) begin
                        m_req   <= 1'b0;
                        m_we    <= 1'b0;
                        bus_err <= rsp[1];
                        state   <= IDLE;
                        if (rsp[1]) err_seen <= 1'b1;
                        if (state == BUSY_I) begin
                            if_ready <= rsp[0];
                            if_rdata <= rsp[1] ? '0 : m_rdata;
                        end else begin
                            d_ready <= rsp[0];
                            // A completed store leaves the load data register untouched.
                            if (rsp[1]) d_rdata <= '0;
                            else if (!m_we) d_rdata <= m_rdata;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign stall_f = if_req & ~if_ready;
    assign stall_m = d_req & ~d_ready;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: fetch, load/store, alternation, fetch starvation guard,
// timeout abort, late ack and asynchronous reset mid-access.
module tb_mem_arbiter;

    logic        clk;
    logic        reset;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_ready;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [31:0] d_rdata;
    logic        d_ready;
    logic        stall_f;
    logic        stall_m;
    logic        m_req;
    logic        m_we;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic [31:0] m_rdata;
    logic        m_ack;
    logic        bus_err;
    logic        err_seen;

    int checks;
    int failures;

    mem_arbiter #(.STREAK_MAX(4), .TIMEOUT(8)) dut (
        .clk      (clk),
        .reset    (reset),
        .if_req   (if_req),
        .if_addr  (if_addr),
        .if_rdata (if_rdata),
        .if_ready (if_ready),
        .d_req    (d_req),
        .d_we     (d_we),
        .d_addr   (d_addr),
        .d_wdata  (d_wdata),
        .d_rdata  (d_rdata),
        .d_ready  (d_ready),
        .stall_f  (stall_f),
        .stall_m  (stall_m),
        .m_req    (m_req),
        .m_we     (m_we),
        .m_addr   (m_addr),
        .m_wdata  (m_wdata),
        .m_rdata  (m_rdata),
        .m_ack    (m_ack),
        .bus_err  (bus_err),
        .err_seen (err_seen)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        reset    = 1'b0;
        if_req   = 1'b0;
        if_addr  = '0;
        d_req    = 1'b0;
        d_we     = 1'b0;
        d_addr   = '0;
        d_wdata  = '0;
        m_rdata  = '0;
        m_ack    = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkEq("rst_mreq", m_req, 0);
        checkEq("rst_mwe", m_we, 0);
        checkEq("rst_iready", if_ready, 0);
        checkEq("rst_dready", d_ready, 0);
        checkEq("rst_buserr", bus_err, 0);
        checkEq("rst_errseen", err_seen, 0);
        checkEq("rst_maddr", m_addr, 0);
        checkEq("rst_mwdata", m_wdata, 0);
        checkEq("rst_irdata", if_rdata, 0);
        checkEq("rst_drdata", d_rdata, 0);
        step();
        reset = 1'b1;

        // Fetch with one wait cycle, then request dropped after if_ready
        step();
        if_req  = 1'b1;
        if_addr = 32'h0040_0000;
        @(negedge clk);
        checkEq("f0_mreq", m_req, 0);
        checkEq("f0_stallf", stall_f, 1);
        step();
        @(negedge clk);
        checkEq("f1_mreq", m_req, 1);
        checkEq("f1_maddr", m_addr, 32'h0040_0000);
        checkEq("f1_mwe", m_we, 0);
        checkEq("f1_stallf", stall_f, 1);
        step();
        m_ack   = 1'b1;
        m_rdata = 32'h2002_0005;
        @(negedge clk);
        checkEq("f2_iready", if_ready, 0);
        step();
        m_ack   = 1'b0;
        m_rdata = '0;
        @(negedge clk);
        checkEq("f3_iready", if_ready, 1);
        checkEq("f3_irdata", if_rdata, 32'h2002_0005);
        checkEq("f3_stallf", stall_f, 0);
        checkEq("f3_mreq", m_req, 0);
        step();
        if_req = 1'b0;
        @(negedge clk);
        checkEq("f4_iready", if_ready, 0);
        checkEq("f4_mreq", m_req, 0);
        step();
        @(negedge clk);
        checkEq("f5_mreq", m_req, 0);

        // Load, then store whose inputs change while busy
        step();
        d_req  = 1'b1;
        d_we   = 1'b0;
        d_addr = 32'h10;
        @(negedge clk);
        checkEq("ld0_stallm", stall_m, 1);
        step();
        m_ack   = 1'b1;
        m_rdata = 32'hCAFE_F00D;
        @(negedge clk);
        checkEq("ld1_maddr", m_addr, 32'h10);
        checkEq("ld1_mwe", m_we, 0);
        step();
        m_ack = 1'b0;
        @(negedge clk);
        checkEq("ld2_dready", d_ready, 1);
        checkEq("ld2_drdata", d_rdata, 32'hCAFE_F00D);
        checkEq("ld2_stallm", stall_m, 0);
        step();
        d_we    = 1'b1;
        d_addr  = 32'h54;
        d_wdata = 32'd7;
        @(negedge clk);
        checkEq("st0_dready", d_ready, 0);
        step();
        d_addr  = 32'h99;
        d_wdata = 32'hFF;
        @(negedge clk);
        checkEq("st1_mreq", m_req, 1);
        checkEq("st1_mwe", m_we, 1);
        checkEq("st1_maddr", m_addr, 32'h54);
        checkEq("st1_mwdata", m_wdata, 32'd7);
        step();
        @(negedge clk);
        checkEq("st2_mwe", m_we, 1);
        checkEq("st2_maddr", m_addr, 32'h54);
        checkEq("st2_mwdata", m_wdata, 32'd7);
        step();
        m_ack   = 1'b1;
        m_rdata = 32'h1234_5678;
        @(negedge clk);
        checkEq("st3_mwe", m_we, 1);
        step();
        m_ack = 1'b0;
        @(negedge clk);
        checkEq("st4_dready", d_ready, 1);
        checkEq("st4_drdata", d_rdata, 32'hCAFE_F00D);
        checkEq("st4_mreq", m_req, 0);
        checkEq("st4_mwe", m_we, 0);
        step();
        d_req = 1'b0;
        d_we  = 1'b0;
        @(negedge clk);
        checkEq("st5_dready", d_ready, 0);

        // Both requesting continuously with zero-wait memory: ports alternate
        for (int c = 0; c < 13; c++) begin
            step();
            if (c == 0) begin
                if_req  = 1'b1;
                d_req   = 1'b1;
                d_addr  = 32'h100;
                if_addr = 32'h0040_0100;
                m_ack   = 1'b1;
                m_rdata = 32'h1111_0000;
            end
            @(negedge clk);
            checkEq("alt_dready", d_ready, 32'((c % 4) == 2));
            checkEq("alt_iready", if_ready, 32'(((c % 4) == 0) && (c > 0)));
            if ((c % 4) == 1) checkEq("alt_maddr_d", m_addr, 32'h100);
            if ((c % 4) == 3) checkEq("alt_maddr_i", m_addr, 32'h0040_0100);
        end
        step();
        if_req = 1'b0;
        d_req  = 1'b0;
        step();
        step();
        m_ack = 1'b0;
        @(negedge clk);
        checkEq("alt_end_mreq", m_req, 0);

        // Fetch request present at each data grant: four data grants, then fetch wins
        for (int c = 0; c < 20; c++) begin
            step();
            d_req   = (c <= 17);
            d_we    = 1'b0;
            d_addr  = 32'h200;
            if_addr = 32'h0040_0200;
            if_req  = ((c >= 3) && (c < 15) && ((c % 3) == 0)) || ((c >= 15) && (c <= 17));
            m_ack   = 1'b1;
            m_rdata = 32'h5555_AAAA;
            @(negedge clk);
            checkEq("stk_dready", d_ready, 32'((((c % 3) == 2) && (c <= 14)) || (c == 19)));
            checkEq("stk_iready", if_ready, 32'(c == 17));
            if (c == 16) checkEq("stk_maddr_i", m_addr, 32'h0040_0200);
            if (((c % 3) == 1) && (c <= 13)) checkEq("stk_maddr_d", m_addr, 32'h200);
        end
        step();
        if_req = 1'b0;
        d_req  = 1'b0;
        m_ack  = 1'b0;

        // No ack: abort after TIMEOUT busy cycles
        for (int c = 0; c < 11; c++) begin
            step();
            if (c == 0) begin
                d_req  = 1'b1;
                d_addr = 32'h300;
            end
            if (c == 10) d_req = 1'b0;
            @(negedge clk);
            checkEq("ab_mreq", m_req, 32'((c >= 1) && (c <= 8)));
            checkEq("ab_dready", d_ready, 32'(c == 9));
            checkEq("ab_buserr", bus_err, 32'(c == 9));
            checkEq("ab_errseen", err_seen, 32'(c >= 9));
            if (c == 8) checkEq("ab_drdata_pre", d_rdata, 32'h5555_AAAA);
            if (c == 9) checkEq("ab_drdata", d_rdata, 32'h0);
        end

        // Ack arriving in the abort cycle completes normally
        for (int c = 0; c < 11; c++) begin
            step();
            if (c == 0) begin
                d_req  = 1'b1;
                d_addr = 32'h304;
            end
            if (c == 8) begin
                m_ack   = 1'b1;
                m_rdata = 32'h0BAD_BEEF;
            end
            if (c == 9) m_ack = 1'b0;
            if (c == 10) d_req = 1'b0;
            @(negedge clk);
            if (c == 8) checkEq("la_mreq", m_req, 1);
            if (c == 9) begin
                checkEq("la_dready", d_ready, 1);
                checkEq("la_buserr", bus_err, 0);
                checkEq("la_drdata", d_rdata, 32'h0BAD_BEEF);
                checkEq("la_errseen", err_seen, 1);
            end
        end

        // Asynchronous reset in the middle of a data access
        step();
        d_req  = 1'b1;
        d_addr = 32'h400;
        m_ack  = 1'b0;
        step();
        @(negedge clk);
        checkEq("rb1_mreq", m_req, 1);
        step();
        @(negedge clk);
        checkEq("rb2_mreq", m_req, 1);
        #1;
        reset = 1'b0;
        #1;
        checkEq("rb_async_mreq", m_req, 0);
        checkEq("rb_async_errseen", err_seen, 0);
        checkEq("rb_async_maddr", m_addr, 0);
        checkEq("rb_async_drdata", d_rdata, 0);
        step();
        @(negedge clk);
        checkEq("rb3_dready", d_ready, 0);
        checkEq("rb3_mreq", m_req, 0);
        step();
        reset = 1'b1;
        @(negedge clk);
        checkEq("rr0_mreq", m_req, 0);
        checkEq("rr0_dready", d_ready, 0);
        step();
        m_ack   = 1'b1;
        m_rdata = 32'h0000_0ABC;
        @(negedge clk);
        checkEq("rr1_mreq", m_req, 1);
        checkEq("rr1_maddr", m_addr, 32'h400);
        step();
        m_ack = 1'b0;
        @(negedge clk);
        checkEq("rr2_dready", d_ready, 1);
        checkEq("rr2_drdata", d_rdata, 32'h0000_0ABC);
        checkEq("rr2_buserr", bus_err, 0);
        step();
        d_req = 1'b0;
        @(negedge clk);
        checkEq("rr3_dready", d_ready, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
